// File: rtl/freq_sched_pkg.sv
// Shared types for the frequency measurement scheduler.
// FSM encodings, default channel count and ID width helper.
package freq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam int NCH_DEFAULT = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// Two-flop synchroniser with rising-edge detect for one
// asynchronous input channel.
module freq_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh <= '0;
    end else begin
      sh <= {sh[1:0], sig};
    end
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/freq_meas_sched.sv
// Round-robin scheduled frequency counter over NCH channels.
// Optional FREQ_SCHED_ABORT_EN: owner req drop aborts MEASURE.
module freq_meas_sched
  import freq_sched_pkg::*;
#(
  parameter  int WINDOW = 5000000,
  parameter  int SCALE  = 10,
  parameter  int NCH    = NCH_DEFAULT,
  localparam int IDW    = id_width(NCH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] sig_in,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] grant,
  output logic           result_valid,
  input  logic           result_ready,
  output logic [31:0]    result_data,
  output logic [IDW-1:0] result_id
);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [31:0]    edge_cnt;
  logic [31:0]    win_cnt;
  logic [NCH-1:0] rise;
  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic           hit;
  logic           abort;
  logic [31:0]    nxt_cnt;
  int             idx;

  for (genvar i = 0; i < NCH; i++) begin : g_sync
    freq_edge_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .sig     (sig_in[i]),
      .rise    (rise[i])
    );
  end

  // First requester at or after ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  assign hit     = |(rise & grant);
  assign nxt_cnt = edge_cnt + 32'(hit);

`ifdef FREQ_SCHED_ABORT_EN
  assign abort = ~req[owner];
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= '0;
      ptr          <= '0;
      owner        <= '0;
      edge_cnt     <= '0;
      win_cnt      <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            state    <= MEASURE;
            grant    <= NCH'(1) << win_idx;
            owner    <= win_idx;
            ptr      <= IDW'((int'(win_idx) + 1) % NCH);
            edge_cnt <= '0;
            win_cnt  <= '0;
          end
        end
        MEASURE: begin
          if (abort) begin
            state <= IDLE;
            grant <= '0;
          end else begin
            edge_cnt <= nxt_cnt;
            win_cnt  <= win_cnt + 32'd1;
            if (win_cnt == 32'(WINDOW - 1)) begin
              state        <= REPORT;
              result_valid <= 1'b1;
              result_data  <= nxt_cnt * 32'(SCALE);
              result_id    <= owner;
            end
          end
        end
        REPORT: begin
          if (result_ready) begin
            state        <= IDLE;
            grant        <= '0;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_sched.sv
// Directed self-checking bench for freq_meas_sched.
// Uses WINDOW=100, SCALE=10, NCH=4.
module tb_freq_meas_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  sig_in = '0;
  logic [3:0]  req = '0;
  logic [3:0]  grant;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [31:0] result_data;
  logic [1:0]  result_id;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int gen_cnt = 0;

  freq_meas_sched #(
    .WINDOW (100),
    .SCALE  (10),
    .NCH    (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sig_in       (sig_in),
    .req          (req),
    .grant        (grant),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_id    (result_id)
  );

  always #10 clk = ~clk;

  // ch0 period 10, ch1 period 4, ch3 period 14, ch2 static low
  always @(negedge clk) begin
    gen_cnt = gen_cnt + 1;
    if (gen_cnt % 5 == 0) sig_in[0] = ~sig_in[0];
    if (gen_cnt % 2 == 0) sig_in[1] = ~sig_in[1];
    if (gen_cnt % 7 == 0) sig_in[3] = ~sig_in[3];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int lim, output int n);
    n = 0;
    while (grant == 4'b0000 && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!result_valid && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    #5;
    chk_cnt++;
    if ({grant, result_valid, result_data, result_id} !== 39'd0)
      $display("FAIL reset_outputs got g=%b v=%b d=%0d id=%0d want 0",
               grant, result_valid, result_data, result_id);
    else pass_cnt++;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk_cnt++;
    if (grant !== 4'b0000 || result_valid !== 1'b0)
      $display("FAIL idle_after_reset got g=%b v=%b want 0 0",
               grant, result_valid);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int n;
    req = 4'b0001;
    result_ready = 1'b1;
    tick();
    chk_cnt++;
    if (grant !== 4'b0001)
      $display("FAIL single_grant got %b want 0001", grant);
    else pass_cnt++;
    wait_valid(300, n);
    chk_cnt++;
    if (n !== 100)
      $display("FAIL single_window got %0d cycles want 100", n);
    else pass_cnt++;
    chk_cnt++;
    if (result_valid !== 1'b1 || result_data < 90 || result_data > 110)
      $display("FAIL single_data got v=%b d=%0d want 1 90..110",
               result_valid, result_data);
    else pass_cnt++;
    chk_cnt++;
    if (result_id !== 2'd0)
      $display("FAIL single_id got %0d want 0", result_id);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    chk_cnt++;
    if (grant !== 4'b0000 || result_valid !== 1'b0)
      $display("FAIL single_idle got g=%b v=%b want 0000 0",
               grant, result_valid);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int n;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = 4'b1111;
    result_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_grant(5, n);
      chk_cnt++;
      if (grant !== exp_g[i])
        $display("FAIL rr_grant%0d got %b want %b", i, grant, exp_g[i]);
      else pass_cnt++;
      wait_valid(200, n);
      chk_cnt++;
      if (result_valid !== 1'b1 || result_id !== 2'(i % 4))
        $display("FAIL rr_id%0d got v=%b id=%0d want 1 %0d",
                 i, result_valid, result_id, i % 4);
      else pass_cnt++;
      tick();
      if (i == 4) req = 4'b0000;
      chk_cnt++;
      if (grant !== 4'b0000 || result_valid !== 1'b0)
        $display("FAIL rr_gap%0d got g=%b v=%b want 0000 0",
                 i, grant, result_valid);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] cap_d;
    logic [1:0]  cap_id;
    int bad;
    req = 4'b0001;
    result_ready = 1'b0;
    wait_grant(5, n);
    wait_valid(200, n);
    chk_cnt++;
    if (result_valid !== 1'b1 || result_data < 90 || result_data > 110)
      $display("FAIL bp_first got v=%b d=%0d want 1 90..110",
               result_valid, result_data);
    else pass_cnt++;
    cap_d = result_data;
    cap_id = result_id;
    req = 4'b0000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (result_valid !== 1'b1 || result_data !== cap_d ||
          result_id !== cap_id || grant !== 4'b0001)
        bad++;
    end
    chk_cnt++;
    if (bad !== 0)
      $display("FAIL bp_stable got %0d unstable cycles want 0", bad);
    else pass_cnt++;
    result_ready = 1'b1;
    tick();
    chk_cnt++;
    if (result_valid !== 1'b0 || grant !== 4'b0000)
      $display("FAIL bp_release got v=%b g=%b want 0 0000",
               result_valid, grant);
    else pass_cnt++;
  endtask

  task automatic test_static();
    int n;
    req = 4'b0100;
    result_ready = 1'b0;
    wait_grant(5, n);
    chk_cnt++;
    if (grant !== 4'b0100)
      $display("FAIL static_grant got %b want 0100", grant);
    else pass_cnt++;
    wait_valid(200, n);
    chk_cnt++;
    if (result_valid !== 1'b1 || result_data !== 32'd0 || result_id !== 2'd2)
      $display("FAIL static_result got v=%b d=%0d id=%0d want 1 0 2",
               result_valid, result_data, result_id);
    else pass_cnt++;
    req = 4'b0000;
    result_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_owner_drop();
    int n;
    int seen;
    req = 4'b0001;
    result_ready = 1'b1;
    wait_grant(5, n);
    repeat (49) tick();
    req = 4'b0000;
`ifdef FREQ_SCHED_ABORT_EN
    tick();
    chk_cnt++;
    if (grant !== 4'b0000 || result_valid !== 1'b0)
      $display("FAIL drop_abort got g=%b v=%b want 0000 0",
               grant, result_valid);
    else pass_cnt++;
    seen = 0;
    repeat (120) begin
      tick();
      if (result_valid) seen++;
    end
    chk_cnt++;
    if (seen !== 0)
      $display("FAIL drop_noresult got %0d valid cycles want 0", seen);
    else pass_cnt++;
`else
    seen = 0;
    wait_valid(150, n);
    chk_cnt++;
    if (result_valid !== 1'b1 || result_id !== 2'd0 || grant !== 4'b0001)
      $display("FAIL drop_report got v=%b id=%0d g=%b want 1 0 0001",
               result_valid, result_id, grant);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (result_valid !== 1'b0 || grant !== 4'b0000)
      $display("FAIL drop_idle got v=%b g=%b want 0 0000",
               result_valid, grant);
    else pass_cnt++;
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    req = 4'b0001;
    result_ready = 1'b1;
    wait_grant(5, n);
    repeat (30) tick();
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({grant, result_valid, result_data, result_id} !== 39'd0)
      $display("FAIL midreset_out got g=%b v=%b d=%0d id=%0d want 0",
               grant, result_valid, result_data, result_id);
    else pass_cnt++;
    tick();
    reset_n = 1'b1;
    req = 4'b0011;
    tick();
    chk_cnt++;
    if (grant !== 4'b0001 || result_valid !== 1'b0)
      $display("FAIL midreset_rr got g=%b v=%b want 0001 0",
               grant, result_valid);
    else pass_cnt++;
    req = 4'b0000;
    wait_valid(200, n);
    chk_cnt++;
    if (result_valid !== 1'b1 || result_id !== 2'd0)
      $display("FAIL midreset_next got v=%b id=%0d want 1 0",
               result_valid, result_id);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_static();
    test_owner_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
